// File: rtl/sic_input_device_if.sv
// Bus bundle for sic_input_device: producer push port and CPU RD/TD port.
// Optional SIC_INDEV_OVERRUN_EN adds the sticky overrun flag.
interface sic_input_device_if #(parameter int DEPTH = 4);
  // Producer side: a byte moves when ext_valid && ext_ready at a rising edge;
  // ext_ready depends on registered state only, never on ext_valid or read_enable.
  // CPU side: read_enable is a one-cycle RD strobe, honoured only while device_ready.
  logic                      ext_valid;
  logic [7:0]                ext_data;
  logic                      ext_ready;
  logic                      read_enable;
  logic                      device_ready;
  logic [7:0]                out_data;
  logic                      read_event;
  logic [$clog2(DEPTH):0]    level;
`ifdef SIC_INDEV_OVERRUN_EN
  logic                      overrun;
`endif

  modport master (
    output ext_valid, ext_data, read_enable,
    input  ext_ready, device_ready, out_data, read_event, level
`ifdef SIC_INDEV_OVERRUN_EN
    , input overrun
`endif
  );

  modport slave (
    input  ext_valid, ext_data, read_enable,
    output ext_ready, device_ready, out_data, read_event, level
`ifdef SIC_INDEV_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/sic_input_device.sv
// SIC byte input device: producer-fed FIFO drained by the CPU RD instruction.
// Define SIC_INDEV_OVERRUN_EN to add a sticky flag for bytes offered while full.
module sic_input_device #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  sic_input_device_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [7:0]    out_q;
  logic          read_event_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // Full blocks the push even when a pop happens in the same cycle, which keeps
  // read_enable out of the ext_ready path.
  assign push  = bus.ext_valid && !full;
  assign pop   = bus.read_enable && !empty;

  assign bus.ext_ready    = !full;
  assign bus.device_ready = !empty;
  assign bus.out_data     = out_q;
  assign bus.read_event   = read_event_q;
  assign bus.level        = level_q;

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.ext_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      out_q        <= 8'd0;
      read_event_q <= 1'b0;
    end else begin
      read_event_q <= pop;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        out_q  <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef SIC_INDEV_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (bus.ext_valid && full) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.overrun = overrun_q;
`endif
endmodule

// File: tb/tb_sic_input_device.sv
// Directed bench for sic_input_device (DEPTH=4): vector table plus sequences
// for pointer wrap under simultaneous push/pop and asynchronous reset.
module tb_sic_input_device;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sic_input_device_if #(.DEPTH(4)) bus ();

  sic_input_device #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rd;
    logic       exp_er;
    logic       exp_dr;
    logic [7:0] exp_od;
    logic       exp_re;
    logic [2:0] exp_lvl;
    logic       exp_ov;
  } vec_t;

  vec_t            vecs[$];
  logic [7:0]      exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rd,
                     input logic er, input logic dr, input logic [7:0] od,
                     input logic re, input logic [2:0] lvl, input logic ov);
    vec_t x;
    x.v = v; x.d = d; x.rd = rd;
    x.exp_er = er; x.exp_dr = dr; x.exp_od = od;
    x.exp_re = re; x.exp_lvl = lvl; x.exp_ov = ov;
    vecs.push_back(x);
  endtask

  task automatic check_outputs(input string tag, input logic er, input logic dr,
                               input logic [7:0] od, input logic re,
                               input logic [2:0] lvl, input logic ov);
    check({tag, " ext_ready"},    32'(bus.ext_ready),    32'(er));
    check({tag, " device_ready"}, 32'(bus.device_ready), 32'(dr));
    check({tag, " out_data"},     32'(bus.out_data),     32'(od));
    check({tag, " read_event"},   32'(bus.read_event),   32'(re));
    check({tag, " level"},        32'(bus.level),        32'(lvl));
`ifdef SIC_INDEV_OVERRUN_EN
    check({tag, " overrun"},      32'(bus.overrun),      32'(ov));
`else
    if (ov !== ov) check({tag, " overrun"}, 32'(ov), 32'(ov));
`endif
  endtask

  // Driver: inputs change 1 time unit after an edge, outputs sampled at the same point.
  task automatic run_vec(input vec_t x, input string tag);
    bus.ext_valid   = x.v;
    bus.ext_data    = x.d;
    bus.read_enable = x.rd;
    @(posedge clk);
    #1;
    check_outputs(tag, x.exp_er, x.exp_dr, x.exp_od, x.exp_re, x.exp_lvl, x.exp_ov);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rd);
    bus.ext_valid   = v;
    bus.ext_data    = d;
    bus.read_enable = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       x;
    logic [7:0] e;
    checks = 0;
    errors = 0;
    bus.ext_valid   = 1'b0;
    bus.ext_data    = 8'h00;
    bus.read_enable = 1'b0;
    rst = 1'b1;
    #3;
    check_outputs("reset", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    //  v   data   rd    er    dr    od     re    lvl   ov
    add(0, 8'h00, 0,    1,    0,    8'h00, 0,    3'd0, 0);  // idle
    add(0, 8'h00, 1,    1,    0,    8'h00, 0,    3'd0, 0);  // RD on empty
    add(1, 8'h41, 0,    1,    1,    8'h00, 0,    3'd1, 0);  // push 41
    add(0, 8'h00, 1,    1,    0,    8'h41, 1,    3'd0, 0);  // RD -> 41
    add(0, 8'h00, 0,    1,    0,    8'h41, 0,    3'd0, 0);  // pulse ends, data held
    add(1, 8'h10, 0,    1,    1,    8'h41, 0,    3'd1, 0);
    add(1, 8'h11, 0,    1,    1,    8'h41, 0,    3'd2, 0);
    add(1, 8'h12, 0,    1,    1,    8'h41, 0,    3'd3, 0);
    add(1, 8'h13, 0,    0,    1,    8'h41, 0,    3'd4, 0);  // full
    add(1, 8'h14, 0,    0,    1,    8'h41, 0,    3'd4, 1);  // rejected
    add(0, 8'h00, 1,    1,    1,    8'h10, 1,    3'd3, 1);
    add(0, 8'h00, 1,    1,    1,    8'h11, 1,    3'd2, 1);
    add(0, 8'h00, 1,    1,    1,    8'h12, 1,    3'd1, 1);
    add(0, 8'h00, 1,    1,    0,    8'h13, 1,    3'd0, 1);  // 14 never stored
    add(0, 8'h00, 1,    1,    0,    8'h13, 0,    3'd0, 1);
    add(1, 8'h20, 0,    1,    1,    8'h13, 0,    3'd1, 1);
    add(1, 8'h21, 0,    1,    1,    8'h13, 0,    3'd2, 1);
    add(1, 8'h22, 0,    1,    1,    8'h13, 0,    3'd3, 1);
    add(1, 8'h23, 0,    0,    1,    8'h13, 0,    3'd4, 1);
    add(1, 8'h24, 1,    1,    1,    8'h20, 1,    3'd3, 1);  // full: pop only
    add(1, 8'h24, 0,    0,    1,    8'h20, 0,    3'd4, 1);  // held byte accepted
    add(0, 8'h00, 1,    1,    1,    8'h21, 1,    3'd3, 1);
    add(0, 8'h00, 1,    1,    1,    8'h22, 1,    3'd2, 1);
    add(0, 8'h00, 1,    1,    1,    8'h23, 1,    3'd1, 1);
    add(0, 8'h00, 1,    1,    0,    8'h24, 1,    3'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Level 2 with simultaneous push/pop; eight rounds wrap both pointers.
    drive(1'b1, 8'hA0, 1'b0); exp_q.push_back(8'hA0);
    drive(1'b1, 8'hA1, 1'b0); exp_q.push_back(8'hA1);
    check("wrap prefill level", 32'(bus.level), 32'd2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'hA2 + i), 1'b1);
      exp_q.push_back(8'(8'hA2 + i));
      e = exp_q.pop_front();
      check($sformatf("wrap%0d out_data", i), 32'(bus.out_data), 32'(e));
      check($sformatf("wrap%0d level", i), 32'(bus.level), 32'd2);
      check($sformatf("wrap%0d read_event", i), 32'(bus.read_event), 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      check($sformatf("wrap drain%0d out_data", i), 32'(bus.out_data), 32'(e));
    end
    check("wrap drained device_ready", 32'(bus.device_ready), 32'd0);

    // Asynchronous reset mid-stream at level 3.
    drive(1'b1, 8'h61, 1'b0);
    drive(1'b1, 8'h62, 1'b0);
    drive(1'b1, 8'h63, 1'b0);
    drive(1'b1, 8'h64, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    check_outputs("pre-rst", 1'b1, 1'b1, 8'h61, 1'b1, 3'd3, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async-rst", 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
    bus.read_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    x = '{v:1, d:8'h70, rd:0, exp_er:1, exp_dr:1, exp_od:8'h00, exp_re:0, exp_lvl:3'd1, exp_ov:0};
    run_vec(x, "post-rst push");
    x = '{v:0, d:8'h00, rd:1, exp_er:1, exp_dr:0, exp_od:8'h70, exp_re:1, exp_lvl:3'd0, exp_ov:0};
    run_vec(x, "post-rst rd");
    x = '{v:0, d:8'h00, rd:0, exp_er:1, exp_dr:0, exp_od:8'h70, exp_re:0, exp_lvl:3'd0, exp_ov:0};
    run_vec(x, "post-rst idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
